// File: rtl/game_sprite_motion_pkg.sv
// Shared game configuration: screen geometry, coordinate widths and sprite size defaults.
package game_sprite_motion_pkg;
  localparam int CFG_SCREEN_WIDTH  = 640;
  localparam int CFG_SCREEN_HEIGHT = 480;
  localparam int CFG_X_WIDTH       = 10;
  localparam int CFG_Y_WIDTH       = 10;
  localparam int CFG_DXY_WIDTH     = 4;
  localparam int CFG_SPRITE_WIDTH  = 8;
  localparam int CFG_SPRITE_HEIGHT = 8;
  localparam int CFG_STROBE_PERIOD = 1000000;
endpackage

// File: rtl/game_strobe_gen.sv
// Motion step divider: counts 0..PERIOD-1 while enabled, strobe in the last count.
// Strobe is combinational from the counter; clear or disable restarts at 0.
module game_strobe_gen #(
  parameter int PERIOD = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic strobe
);
  localparam int CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] count;

  assign strobe = enable && (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!enable || clear || strobe) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end
endmodule

// File: rtl/game_sprite_motion.sv
// Per-sprite position/velocity registers stepped by a strobe divider, with on-screen
// flag (combinational) and raster hit flag (1-cycle registered).
module game_sprite_motion
  import game_sprite_motion_pkg::*;
#(
  parameter int SCREEN_WIDTH  = CFG_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = CFG_SCREEN_HEIGHT,
  parameter int X_WIDTH       = CFG_X_WIDTH,
  parameter int Y_WIDTH       = CFG_Y_WIDTH,
  parameter int DXY_WIDTH     = CFG_DXY_WIDTH,
  parameter int SPRITE_WIDTH  = CFG_SPRITE_WIDTH,
  parameter int SPRITE_HEIGHT = CFG_SPRITE_HEIGHT,
  parameter int STROBE_PERIOD = CFG_STROBE_PERIOD
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sprite_write_xy,
  input  logic [X_WIDTH-1:0]   sprite_write_x,
  input  logic [Y_WIDTH-1:0]   sprite_write_y,
  input  logic                 sprite_write_dxy,
  input  logic [DXY_WIDTH-1:0] sprite_write_dx,
  input  logic [DXY_WIDTH-1:0] sprite_write_dy,
  input  logic                 sprite_enable_update,
  input  logic                 display_on,
  input  logic [X_WIDTH-1:0]   pixel_x,
  input  logic [Y_WIDTH-1:0]   pixel_y,
  output logic                 sprite_within_screen,
  output logic                 sprite_rgb_en
);
  // Two guard bits give room to run off either edge without wrapping.
  localparam int XW = X_WIDTH + 2;
  localparam int YW = Y_WIDTH + 2;

  localparam logic signed [XW-1:0] X_LO  = XW'(-SPRITE_WIDTH);
  localparam logic signed [XW-1:0] X_HI  = XW'(SCREEN_WIDTH);
  localparam logic signed [YW-1:0] Y_LO  = YW'(-SPRITE_HEIGHT);
  localparam logic signed [YW-1:0] Y_HI  = YW'(SCREEN_HEIGHT);
  localparam logic signed [XW-1:0] X_BOX = XW'(SPRITE_WIDTH);
  localparam logic signed [YW-1:0] Y_BOX = YW'(SPRITE_HEIGHT);

  logic signed [XW-1:0]        x;
  logic signed [YW-1:0]        y;
  logic signed [DXY_WIDTH-1:0] dx;
  logic signed [DXY_WIDTH-1:0] dy;
  logic                        step;

  logic signed [XW-1:0] dx_ext, x_end, px;
  logic signed [YW-1:0] dy_ext, y_end, py;
  logic                 hit;

  game_strobe_gen #(
    .PERIOD (STROBE_PERIOD)
  ) u_strobe (
    .clk    (clk),
    .reset  (reset),
    .enable (sprite_enable_update),
    .clear  (sprite_write_xy),
    .strobe (step)
  );

  assign dx_ext = XW'(dx);
  assign dy_ext = YW'(dy);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (sprite_write_xy) begin
      x <= signed'(XW'(sprite_write_x));
      y <= signed'(YW'(sprite_write_y));
    end else if (step) begin
      x <= x + dx_ext;
      y <= y + dy_ext;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dx <= '0;
      dy <= '0;
    end else if (sprite_write_dxy) begin
      dx <= signed'(sprite_write_dx);
      dy <= signed'(sprite_write_dy);
    end
  end

  assign sprite_within_screen = (x > X_LO) && (x < X_HI) && (y > Y_LO) && (y < Y_HI);

  assign px    = signed'(XW'(pixel_x));
  assign py    = signed'(YW'(pixel_y));
  assign x_end = x + X_BOX;
  assign y_end = y + Y_BOX;
  assign hit   = display_on && (px >= x) && (px < x_end) && (py >= y) && (py < y_end);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sprite_rgb_en <= 1'b0;
    end else begin
      sprite_rgb_en <= hit;
    end
  end
endmodule

// File: tb/tb_game_sprite_motion.sv
// Directed bench for game_sprite_motion with a short strobe period.
module tb_game_sprite_motion;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sprite_write_xy = 1'b0;
  logic [9:0] sprite_write_x = '0;
  logic [9:0] sprite_write_y = '0;
  logic       sprite_write_dxy = 1'b0;
  logic [3:0] sprite_write_dx = '0;
  logic [3:0] sprite_write_dy = '0;
  logic       sprite_enable_update = 1'b0;
  logic       display_on = 1'b0;
  logic [9:0] pixel_x = '0;
  logic [9:0] pixel_y = '0;
  logic       sprite_within_screen;
  logic       sprite_rgb_en;

  int tests = 0;
  int fails = 0;

  game_sprite_motion #(
    .STROBE_PERIOD (4)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .sprite_write_xy      (sprite_write_xy),
    .sprite_write_x       (sprite_write_x),
    .sprite_write_y       (sprite_write_y),
    .sprite_write_dxy     (sprite_write_dxy),
    .sprite_write_dx      (sprite_write_dx),
    .sprite_write_dy      (sprite_write_dy),
    .sprite_enable_update (sprite_enable_update),
    .display_on           (display_on),
    .pixel_x              (pixel_x),
    .pixel_y              (pixel_y),
    .sprite_within_screen (sprite_within_screen),
    .sprite_rgb_en        (sprite_rgb_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle load of position and/or velocity.
  task automatic load(input bit wxy, input int px, input int py,
                      input bit wdxy, input int vx, input int vy);
    sprite_write_xy  = wxy;
    sprite_write_x   = 10'(px);
    sprite_write_y   = 10'(py);
    sprite_write_dxy = wdxy;
    sprite_write_dx  = 4'(vx);
    sprite_write_dy  = 4'(vy);
    tick();
    sprite_write_xy  = 1'b0;
    sprite_write_dxy = 1'b0;
  endtask

  task automatic raster(input bit on, input int px, input int py, input int exp, input string tag);
    display_on = on;
    pixel_x    = 10'(px);
    pixel_y    = 10'(py);
    tick();
    chk(tag, int'(sprite_rgb_en), exp);
  endtask

  initial begin
    tick(2);
    chk("reset_x", int'(dut.x), 0);
    chk("reset_y", int'(dut.y), 0);
    chk("reset_dx", int'(dut.dx), 0);
    chk("reset_within", int'(sprite_within_screen), 1);
    chk("reset_rgb", int'(sprite_rgb_en), 0);
    reset = 1'b0;

    // Basic motion: +2/-1 per step, four cycles per step.
    load(1'b1, 100, 50, 1'b1, 2, -1);
    chk("load_x", int'(dut.x), 100);
    chk("load_y", int'(dut.y), 50);
    sprite_enable_update = 1'b1;
    tick(11);
    chk("move11_x", int'(dut.x), 104);
    chk("move11_y", int'(dut.y), 48);
    tick();
    chk("move12_x", int'(dut.x), 106);
    chk("move12_y", int'(dut.y), 47);
    sprite_enable_update = 1'b0;
    tick(8);
    chk("hold_x", int'(dut.x), 106);
    chk("hold_count", int'(dut.u_strobe.count), 0);

    // Raster hit box.
    load(1'b1, 20, 30, 1'b1, 0, 0);
    raster(1'b1, 27, 37, 1, "rgb_27_37");
    raster(1'b1, 28, 37, 0, "rgb_28_37");
    raster(1'b0, 27, 37, 0, "rgb_display_off");
    raster(1'b1, 20, 30, 1, "rgb_20_30");
    raster(1'b1, 27, 38, 0, "rgb_27_38");
    raster(1'b1, 19, 30, 0, "rgb_19_30");
    display_on = 1'b0;

    // Right edge.
    load(1'b1, 636, 100, 1'b1, 1, 0);
    chk("edge_within_636", int'(sprite_within_screen), 1);
    sprite_enable_update = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick(4);
      chk("edge_x", int'(dut.x), 636 + k);
      chk("edge_within", int'(sprite_within_screen), (636 + k < 640) ? 1 : 0);
    end

    // Left edge, going negative.
    load(1'b1, 2, 100, 1'b1, -3, 0);
    for (int k = 1; k <= 4; k++) begin
      tick(4);
      chk("left_x", int'(dut.x), 2 - 3 * k);
      chk("left_within", int'(sprite_within_screen), (2 - 3 * k > -8) ? 1 : 0);
    end

    // Position write lands on a step cycle and wins; velocity written alongside.
    tick(3);
    chk("step_cycle", int'(dut.step), 1);
    load(1'b1, 10, 100, 1'b1, 1, 2);
    chk("wxy_win_x", int'(dut.x), 10);
    chk("wxy_dx", int'(dut.dx), 1);
    tick(3);
    chk("restart_hold_x", int'(dut.x), 10);
    tick();
    chk("restart_step_x", int'(dut.x), 11);
    chk("restart_step_y", int'(dut.y), 102);

    // Velocity write on a step cycle only affects the following step.
    tick(3);
    load(1'b0, 0, 0, 1'b1, -2, 0);
    chk("old_dx_x", int'(dut.x), 12);
    chk("old_dx_y", int'(dut.y), 104);
    tick(4);
    chk("new_dx_x", int'(dut.x), 10);
    chk("new_dx_y", int'(dut.y), 104);

    // Reset between edges while moving.
    raster(1'b1, 11, 105, 1, "pre_reset_rgb");
    #2 reset = 1'b1;
    #1;
    chk("mid_reset_x", int'(dut.x), 0);
    chk("mid_reset_y", int'(dut.y), 0);
    chk("mid_reset_dx", int'(dut.dx), 0);
    chk("mid_reset_dy", int'(dut.dy), 0);
    chk("mid_reset_rgb", int'(sprite_rgb_en), 0);
    chk("mid_reset_within", int'(sprite_within_screen), 1);
    chk("mid_reset_count", int'(dut.u_strobe.count), 0);
    tick(3);
    chk("held_reset_x", int'(dut.x), 0);
    sprite_enable_update = 1'b0;
    reset = 1'b0;
    pixel_x = 10'd0;
    pixel_y = 10'd0;
    tick(6);
    chk("post_reset_count", int'(dut.u_strobe.count), 0);
    chk("post_reset_step", int'(dut.step), 0);
    chk("post_reset_rgb", int'(sprite_rgb_en), 1);
    chk("post_reset_x", int'(dut.x), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/game_sprite_motion.md
GAME_SPRITE_MOTION -- requirements
Module: game_sprite_motion

Interface
REQ-001 Parameter SCREEN_WIDTH, default 640: visible pixels per line.
REQ-002 Parameter SCREEN_HEIGHT, default 480: visible lines.
REQ-003 Parameter X_WIDTH / Y_WIDTH, default 10 / 10: unsigned pixel coordinate widths.
REQ-004 Parameter DXY_WIDTH, default 4: signed velocity width, pixels per step.
REQ-005 Parameter SPRITE_WIDTH / SPRITE_HEIGHT, default 8 / 8: sprite box size.
REQ-006 Parameter STROBE_PERIOD, default 1000000: clk cycles per motion step, minimum 2.
REQ-007 clk  in  1  clock; reset  in  1  reset, asynchronous, active-high.
REQ-008 sprite_write_xy  in  1  load position from sprite_write_x/y.
REQ-009 sprite_write_x  in  X_WIDTH, sprite_write_y  in  Y_WIDTH  load position, unsigned.
REQ-010 sprite_write_dxy  in  1  load velocity from sprite_write_dx/dy.
REQ-011 sprite_write_dx / sprite_write_dy  in  DXY_WIDTH each  velocity, two's complement.
REQ-012 sprite_enable_update  in  1  motion enabled while high.
REQ-013 display_on  in  1; pixel_x  in  X_WIDTH; pixel_y  in  Y_WIDTH  current raster pixel.
REQ-014 sprite_within_screen  out  1  sprite box overlaps visible screen.
REQ-015 sprite_rgb_en  out  1  raster pixel lies inside sprite box, registered.

Function
REQ-016 Position x, y SHALL be held as signed registers of X_WIDTH+2 / Y_WIDTH+2 bits; no wrap-around within the legal motion range.
REQ-017 sprite_write_xy SHALL load x, y (zero-extended) on the next clk edge.
REQ-018 sprite_write_dxy SHALL load dx, dy on the next clk edge.
REQ-019 Strobe counter SHALL count 0..STROBE_PERIOD-1 while sprite_enable_update high; step pulse asserted in the cycle count equals STROBE_PERIOD-1, count then wraps to 0.
REQ-020 sprite_enable_update low SHALL hold counter at 0; no step.
REQ-021 On a step, x <= x + sign-extended dx and y <= y + sign-extended dy, using registered dx/dy (a same-cycle write_dxy affects the next step only).
REQ-022 write_xy coincident with a step SHALL win: position takes written value, counter restarts at 0.
REQ-023 write_xy and write_dxy in the same cycle SHALL both take effect.
REQ-024 sprite_within_screen SHALL be combinational from x, y: x > -SPRITE_WIDTH and x < SCREEN_WIDTH and y > -SPRITE_HEIGHT and y < SCREEN_HEIGHT.
REQ-025 sprite_rgb_en SHALL be registered, 1-cycle latency: high iff display_on and x <= pixel_x < x+SPRITE_WIDTH and y <= pixel_y < y+SPRITE_HEIGHT, all compared signed.
REQ-026 Sprite at edge (x = SCREEN_WIDTH-1) SHALL report within_screen 1; x = SCREEN_WIDTH SHALL report 0.
REQ-027 Once off screen the sprite SHALL keep moving while enabled; within_screen stays 0 until a write_xy.

Reset
REQ-028 Reset SHALL clear x, y, dx, dy, strobe counter and sprite_rgb_en to 0.
REQ-029 During and after reset sprite_within_screen SHALL be 1 (position 0,0).
REQ-030 Reset asserted mid-step SHALL abort the update; no partial position change.

Structure
REQ-031 SCREEN_WIDTH, SCREEN_HEIGHT, X_WIDTH, Y_WIDTH, DXY_WIDTH, sprite size defaults SHALL live in the shared game_config header.
REQ-032 Strobe divider SHALL be sub-module game_strobe_gen (inputs clk, reset, enable, clear; output strobe).
REQ-033 One game_sprite_motion instance per sprite; the game master's target/torpedo write_xy, write_dxy, enable_update connect directly.

Verification
REQ-034 write_xy x=100,y=50, write_dxy dx=+2,dy=-1, enable, STROBE_PERIOD=4 -> after 3 steps (12 cycles) x=106, y=47.
REQ-035 x=636, dx=+1, enable -> within_screen 1 through x=639, 0 when x=640, stays 0.
REQ-036 x=2, dx=-3 -> after 4 steps x=-10 (SPRITE_WIDTH 8), within_screen 0; no wrap to large positive.
REQ-037 write_xy x=10 in step cycle -> x=10 next cycle, next step exactly STROBE_PERIOD cycles later.
REQ-038 x=20,y=30, raster pixel (27,37) display_on=1 -> sprite_rgb_en 1 one cycle later; (28,37) -> 0; display_on=0 -> 0.
REQ-039 Assert reset mid-motion -> x=y=dx=dy=0, rgb_en 0, within_screen 1 immediately, no step until enable.
